// File: rtl/wb_intc_pkg.sv
// Shared definitions for the wb_intc interrupt controller: register offsets
// (decoded from wb_adr_i[3:2]) and the VECTOR register layout.
package wb_intc_pkg;

  typedef enum logic [1:0] {
    INTC_PENDING = 2'd0,
    INTC_MASK    = 2'd1,
    INTC_STATUS  = 2'd2,
    INTC_VECTOR  = 2'd3
  } intc_reg_e;

  localparam int unsigned INTC_VEC_VALID_BIT = 31;
  localparam int unsigned INTC_VEC_IDX_W     = 5;

endpackage

// File: rtl/wb_intc_if.sv
// Wishbone slave bus bundle for wb_intc. The master modport is the bus side
// (CPU / interconnect or a testbench); the slave modport is the controller.
interface wb_intc_if #(
  parameter int unsigned wb_dat_width = 32,
  parameter int unsigned wb_adr_width = 32
);

  logic [wb_adr_width-1:0] wb_adr_i;
  logic [wb_dat_width-1:0] wb_dat_i;
  logic                    wb_we_i;
  logic                    wb_cyc_i;
  logic                    wb_stb_i;
  logic                    wb_ack_o;
  logic [wb_dat_width-1:0] wb_dat_o;

  modport master (
    output wb_adr_i, wb_dat_i, wb_we_i, wb_cyc_i, wb_stb_i,
    input  wb_ack_o, wb_dat_o
  );

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_we_i, wb_cyc_i, wb_stb_i,
    output wb_ack_o, wb_dat_o
  );

endinterface

// File: rtl/wb_intc_prio_enc.sv
// Lowest-index-first priority encoder. Used by wb_intc to build the VECTOR
// register when WB_INTC_VECTOR_EN is defined.
module intc_prio_enc #(
  parameter int unsigned W     = 8,
  parameter int unsigned IDX_W = 5
) (
  input  logic [W-1:0]     req,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  // Scan upward and keep the first set bit found.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < W; i++) begin
      if (req[i] && !valid) begin
        valid = 1'b1;
        idx   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/wb_intc.sv
// Wishbone interrupt controller: edge-detects NUM_SRC sources into a W1C
// pending register, gates them with MASK and drives one registered irq_o.
// Optional VECTOR register (lowest pending&mask index) under the macro
// WB_INTC_VECTOR_EN; without it VECTOR reads 0 and no encoder is built.
module wb_intc
  import wb_intc_pkg::*;
#(
  parameter int unsigned NUM_SRC      = 8,
  parameter int unsigned wb_dat_width = 32,
  parameter int unsigned wb_adr_width = 32
) (
  input  logic               clk,
  input  logic               rst,
  wb_intc_if.slave           bus,
  input  logic [NUM_SRC-1:0] irq_src_i,
  output logic               irq_o
);

  logic [NUM_SRC-1:0]      src_q;
  logic [NUM_SRC-1:0]      pending;
  logic [NUM_SRC-1:0]      mask;
  logic [NUM_SRC-1:0]      status;
  logic [NUM_SRC-1:0]      rise;
  logic [NUM_SRC-1:0]      clr;
  logic                    ack;
  logic                    req;
  logic                    wr_pending;
  logic                    wr_mask;
  logic [wb_dat_width-1:0] rdata;
  logic [wb_dat_width-1:0] dat_q;
  logic                    irq_q;
  intc_reg_e               sel;
  logic                    unused_bits;

  assign sel        = intc_reg_e'(bus.wb_adr_i[3:2]);
  assign req        = bus.wb_stb_i & bus.wb_cyc_i & ~ack;
  assign wr_pending = req & bus.wb_we_i & (sel == INTC_PENDING);
  assign wr_mask    = req & bus.wb_we_i & (sel == INTC_MASK);
  assign rise       = irq_src_i & ~src_q;
  assign clr        = wr_pending ? bus.wb_dat_i[NUM_SRC-1:0] : '0;
  assign status     = pending & mask;

  assign bus.wb_ack_o = bus.wb_stb_i & bus.wb_cyc_i & ack;
  assign bus.wb_dat_o = dat_q;
  assign irq_o        = irq_q;

  assign unused_bits = ^{bus.wb_adr_i[wb_adr_width-1:4], bus.wb_adr_i[1:0],
                         bus.wb_dat_i[wb_dat_width-1:NUM_SRC]};

`ifdef WB_INTC_VECTOR_EN
  logic                      vec_valid;
  logic [INTC_VEC_IDX_W-1:0] vec_idx;
  logic [wb_dat_width-1:0]   vec_word;

  intc_prio_enc #(
    .W     (NUM_SRC),
    .IDX_W (INTC_VEC_IDX_W)
  ) u_prio_enc (
    .req   (status),
    .valid (vec_valid),
    .idx   (vec_idx)
  );

  // Assemble the VECTOR word: valid flag on top, winning index at the bottom.
  always_comb begin
    vec_word                           = '0;
    vec_word[INTC_VEC_VALID_BIT]       = vec_valid;
    vec_word[INTC_VEC_IDX_W-1:0]       = vec_idx;
  end
`endif

  // Read multiplexer over the four registers; upper bits zero-filled.
  always_comb begin
    rdata = '0;
    unique case (sel)
      INTC_PENDING: rdata = wb_dat_width'(pending);
      INTC_MASK:    rdata = wb_dat_width'(mask);
      INTC_STATUS:  rdata = wb_dat_width'(status);
`ifdef WB_INTC_VECTOR_EN
      INTC_VECTOR:  rdata = vec_word;
`else
      INTC_VECTOR:  rdata = '0;
`endif
      default:      rdata = '0;
    endcase
  end

  // Source history and pending latch; a same-cycle rise beats a W1C clear.
  always_ff @(posedge clk) begin
    if (!rst) begin
      src_q   <= '1;
      pending <= '0;
    end else begin
      src_q   <= irq_src_i;
      pending <= (pending & ~clr) | rise;
    end
  end

  // Mask register, written only by an accepted bus write.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mask <= '0;
    end else if (wr_mask) begin
      mask <= bus.wb_dat_i[NUM_SRC-1:0];
    end
  end

  // Bus handshake: one-cycle ack per accepted request; read data held between reads.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ack   <= 1'b0;
      dat_q <= '0;
    end else begin
      ack <= req;
      if (req && !bus.wb_we_i) begin
        dat_q <= rdata;
      end
    end
  end

  // Registered combined interrupt output.
  always_ff @(posedge clk) begin
    if (!rst) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= |status;
    end
  end

endmodule

// File: tb/tb_wb_intc.sv
// Self-checking bench for wb_intc (8 sources): directed scenarios followed by
// randomized traffic, all checked against a bit-level reference model.
module tb_wb_intc;

  logic       clk;
  logic       rst;
  logic [7:0] src;
  logic       irq;

  wb_intc_if #(.wb_dat_width(32), .wb_adr_width(32)) bus ();

  wb_intc #(
    .NUM_SRC      (8),
    .wb_dat_width (32),
    .wb_adr_width (32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .irq_src_i (src),
    .irq_o     (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned total  = 0;
  int unsigned passed = 0;

  // Reference model state
  int unsigned m_pend;
  int unsigned m_mask;
  int unsigned m_prev;
  bit          m_irq;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] model_read(input int unsigned idx);
    int unsigned st;
    st = m_pend & m_mask;
    case (idx)
      0: return 32'(m_pend);
      1: return 32'(m_mask);
      2: return 32'(st);
      default: begin
`ifdef WB_INTC_VECTOR_EN
        for (int k = 0; k < 8; k++)
          if (((st >> k) & 1) == 1) return 32'h8000_0000 + 32'(k);
`endif
        return 32'h0;
      end
    endcase
  endfunction

  // Advance one clock edge; update the model from what the bench drove.
  task automatic clk_step(input int unsigned w1c, input bit mwr, input int unsigned mval);
    int unsigned cur;
    cur = 32'(src);
    @(posedge clk);
    m_irq = ((m_pend & m_mask) != 0);
    for (int k = 0; k < 8; k++) begin
      if (((cur >> k) & 1) == 1 && ((m_prev >> k) & 1) == 0)
        m_pend = m_pend | (1 << k);
      else if (((w1c >> k) & 1) == 1)
        m_pend = m_pend & ~(32'(1) << k);
    end
    m_prev = cur;
    if (mwr) m_mask = mval & 32'hFF;
    #1;
    check("irq_o", {31'b0, irq}, {31'b0, m_irq});
  endtask

  function automatic logic [31:0] mk_adr(input int unsigned idx);
    return ($urandom & 32'hFFFF_FFF0) | (idx << 2) | ($urandom & 32'h3);
  endfunction

  task automatic bus_write(input int unsigned idx, input logic [31:0] data);
    bus.wb_adr_i = mk_adr(idx);
    bus.wb_dat_i = data;
    bus.wb_we_i  = 1'b1;
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    clk_step(idx == 0 ? data : 0, idx == 1, data);
    check("wr_ack", {31'b0, bus.wb_ack_o}, 32'h1);
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    bus.wb_we_i  = 1'b0;
    clk_step(0, 1'b0, 0);
  endtask

  task automatic bus_read(input int unsigned idx, output logic [31:0] data);
    logic [31:0] exp;
    exp = model_read(idx);
    bus.wb_adr_i = mk_adr(idx);
    bus.wb_dat_i = $urandom;
    bus.wb_we_i  = 1'b0;
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    clk_step(0, 1'b0, 0);
    check("rd_ack", {31'b0, bus.wb_ack_o}, 32'h1);
    data = bus.wb_dat_o;
    check($sformatf("rd_data[%0d]", idx), data, exp);
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    clk_step(0, 1'b0, 0);
  endtask

  task automatic model_reset();
    m_pend = 0;
    m_mask = 0;
    m_prev = 32'hFF;
    m_irq  = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    bus.wb_adr_i = '0;
    bus.wb_dat_i = '0;
    bus.wb_we_i  = 1'b0;
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    src = 8'hFF;
    rst = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_irq", {31'b0, irq}, 32'h0);
    check("reset_dat", bus.wb_dat_o, 32'h0);
    rst = 1'b1;

    // Reset state: all registers read 0, sources high at reset exit ignored
    for (int unsigned r = 0; r < 4; r++) begin
      bus_read(r, rd);
      check("reset_reg_zero", rd, 32'h0);
    end
    check("no_trig_at_exit", {31'b0, irq}, 32'h0);
    src = 8'h00;
    clk_step(0, 1'b0, 0);

    // Masked-in pulse on bit 2, then W1C
    bus_write(1, 32'h04);
    src = 8'h04;
    clk_step(0, 1'b0, 0);
    src = 8'h00;
    clk_step(0, 1'b0, 0);
    check("pulse2_irq", {31'b0, irq}, 32'h1);
    bus_read(0, rd);
    check("pulse2_pending", rd, 32'h04);
    bus_write(0, 32'h04);
    check("w1c_irq_low", {31'b0, irq}, 32'h0);

    // Masked-out pulse on bit 5, then unmask
    bus_write(1, 32'h00);
    src = 8'h20;
    clk_step(0, 1'b0, 0);
    src = 8'h00;
    clk_step(0, 1'b0, 0);
    bus_read(0, rd);
    check("pulse5_pending", rd, 32'h20);
    bus_read(2, rd);
    check("pulse5_status", rd, 32'h00);
    check("pulse5_irq", {31'b0, irq}, 32'h0);
    bus_write(1, 32'h20);
    check("unmask_irq", {31'b0, irq}, 32'h1);

    // Rise and W1C of the same bit in one cycle: set wins
    bus_write(0, 32'hFF);
    src = 8'h02;
    bus_write(0, 32'h02);
    src = 8'h00;
    bus_read(0, rd);
    check("collision_pending", rd, 32'h02);

    // Vector register
    bus_write(0, 32'hFF);
    bus_write(1, 32'hFF);
    src = 8'h28;
    clk_step(0, 1'b0, 0);
    src = 8'h00;
    clk_step(0, 1'b0, 0);
    bus_read(3, rd);
`ifdef WB_INTC_VECTOR_EN
    check("vector_28", rd, 32'h8000_0003);
`else
    check("vector_off", rd, 32'h0);
`endif
    bus_write(0, 32'hFF);
    bus_read(3, rd);
    check("vector_empty", rd, 32'h0);

    // Held MASK write aborted by reset
    bus.wb_adr_i = mk_adr(1);
    bus.wb_dat_i = 32'hFF;
    bus.wb_we_i  = 1'b1;
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("rst_no_ack", {31'b0, bus.wb_ack_o}, 32'h0);
    end
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    bus.wb_we_i  = 1'b0;
    rst = 1'b1;
    model_reset();
    bus_read(1, rd);
    check("mask_after_abort", rd, 32'h0);

    // Randomized traffic against the model
    for (int n = 0; n < 300; n++) begin
      int unsigned op;
      if ($urandom_range(0, 2) == 0) src = 8'($urandom);
      op = $urandom_range(0, 5);
      case (op)
        0, 1: clk_step(0, 1'b0, 0);
        2:    bus_write(0, $urandom);
        3:    bus_write(1, $urandom);
        4:    bus_write($urandom_range(2, 3), $urandom);
        default: bus_read($urandom_range(0, 3), rd);
      endcase
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
